// File: rtl/ws2812_decoder.sv
// WS2812 serial line decoder: measures high-pulse widths to recover bits, assembles
// 24-bit pixels, and reports frame latches, partial frames and over-long pulses.
module ws2812_decoder #(
    parameter int BIT_THRESH   = 7,
    parameter int MIN_HIGH     = 2,
    parameter int HIGH_MAX     = 24,
    parameter int RESET_CYCLES = 600,
    parameter int IDX_W        = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    output logic [23:0]      pixel_data,
    output logic             pixel_valid,
    output logic [IDX_W-1:0] pixel_index,
    output logic             frame_end,
    output logic [IDX_W-1:0] frame_len,
    output logic             frame_err,
    output logic             bit_err
);
    localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
    localparam int HIGH_W = $clog2(HIGH_MAX + 1);

    localparam logic [LOW_W-1:0]  LOW_LIM  = LOW_W'(RESET_CYCLES);
    localparam logic [HIGH_W-1:0] HIGH_LIM = HIGH_W'(HIGH_MAX);
    localparam logic [HIGH_W-1:0] HIGH_MIN = HIGH_W'(MIN_HIGH);
    localparam logic [HIGH_W-1:0] ONE_THR  = HIGH_W'(BIT_THRESH);

    typedef enum logic [1:0] {SYNC, LOW, HIGH} state_t;

    state_t            state_q;
    logic              din_m_q, din_s_q, din_p_q;
    logic [LOW_W-1:0]  low_len_q, low_len_d;
    logic [HIGH_W-1:0] high_len_q, high_len_d;
    logic [4:0]        bit_cnt_q;
    logic [IDX_W-1:0]  pix_cnt_q, pix_cnt_d;
    logic [23:0]       shift_q, shift_d;
    logic              rise, fall, bit_val;

    assign rise       = din_s_q & ~din_p_q;
    assign fall       = ~din_s_q & din_p_q;
    assign low_len_d  = (low_len_q == LOW_LIM) ? low_len_q : low_len_q + 1'b1;
    assign high_len_d = (high_len_q == HIGH_LIM) ? high_len_q : high_len_q + 1'b1;
    assign pix_cnt_d  = (pix_cnt_q == '1) ? pix_cnt_q : pix_cnt_q + 1'b1;
    assign bit_val    = (high_len_q >= ONE_THR);
    assign shift_d    = {shift_q[22:0], bit_val};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SYNC;
            din_m_q     <= 1'b0;
            din_s_q     <= 1'b0;
            din_p_q     <= 1'b0;
            low_len_q   <= '0;
            high_len_q  <= '0;
            bit_cnt_q   <= '0;
            pix_cnt_q   <= '0;
            shift_q     <= '0;
            pixel_data  <= '0;
            pixel_valid <= 1'b0;
            pixel_index <= '0;
            frame_end   <= 1'b0;
            frame_len   <= '0;
            frame_err   <= 1'b0;
            bit_err     <= 1'b0;
        end else begin
            din_m_q     <= din;
            din_s_q     <= din_m_q;
            din_p_q     <= din_s_q;
            pixel_valid <= 1'b0;
            frame_end   <= 1'b0;
            frame_err   <= 1'b0;
            bit_err     <= 1'b0;
            case (state_q)
                SYNC: begin
                    bit_cnt_q  <= '0;
                    pix_cnt_q  <= '0;
                    shift_q    <= '0;
                    high_len_q <= '0;
                    if (din_s_q) begin
                        low_len_q <= '0;
                    end else begin
                        // Entering LOW with a saturated gap count suppresses a spurious latch
                        low_len_q <= low_len_d;
                        if (low_len_d == LOW_LIM) state_q <= LOW;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_q    <= HIGH;
                        high_len_q <= HIGH_W'(1);
                        low_len_q  <= '0;
                    end else if (low_len_q != LOW_LIM) begin
                        low_len_q <= low_len_d;
                        if (low_len_d == LOW_LIM) begin
                            if (bit_cnt_q != 5'd0 || pix_cnt_q != '0) begin
                                frame_end <= 1'b1;
                                frame_len <= pix_cnt_q;
                                frame_err <= (bit_cnt_q != 5'd0);
                            end
                            bit_cnt_q <= '0;
                            pix_cnt_q <= '0;
                            shift_q   <= '0;
                        end
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_q   <= LOW;
                        // The falling-edge cycle is already the first low cycle of the gap
                        low_len_q <= LOW_W'(1);
                        if (high_len_q >= HIGH_MIN) begin
                            shift_q <= shift_d;
                            if (bit_cnt_q == 5'd23) begin
                                pixel_data  <= shift_d;
                                pixel_valid <= 1'b1;
                                pixel_index <= pix_cnt_q;
                                pix_cnt_q   <= pix_cnt_d;
                                bit_cnt_q   <= '0;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end else if (high_len_d == HIGH_LIM) begin
                        bit_err    <= 1'b1;
                        state_q    <= SYNC;
                        high_len_q <= high_len_d;
                        low_len_q  <= '0;
                        bit_cnt_q  <= '0;
                        pix_cnt_q  <= '0;
                        shift_q    <= '0;
                    end else begin
                        high_len_q <= high_len_d;
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end
endmodule

// File: tb/tb_ws2812_decoder.sv
// Scoreboard bench for ws2812_decoder: a pulse-level model predicts pixel, latch and
// error events, and a monitor compares them as the DUT strobes.
module tb_ws2812_decoder;
    localparam int BIT_THRESH   = 7;
    localparam int MIN_HIGH     = 2;
    localparam int HIGH_MAX     = 24;
    localparam int RESET_CYCLES = 600;
    localparam int IDX_W        = 3;
    localparam int IDX_MAX      = (1 << IDX_W) - 1;
    localparam int GAP          = 620;

    localparam int K_PIX  = 0;
    localparam int K_FEND = 1;
    localparam int K_BERR = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             din = 1'b0;
    logic [23:0]      pixel_data;
    logic             pixel_valid;
    logic [IDX_W-1:0] pixel_index;
    logic             frame_end;
    logic [IDX_W-1:0] frame_len;
    logic             frame_err;
    logic             bit_err;

    ws2812_decoder #(
        .BIT_THRESH(BIT_THRESH), .MIN_HIGH(MIN_HIGH), .HIGH_MAX(HIGH_MAX),
        .RESET_CYCLES(RESET_CYCLES), .IDX_W(IDX_W)
    ) dut (
        .clk(clk), .rst(rst), .din(din),
        .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_index(pixel_index),
        .frame_end(frame_end), .frame_len(frame_len), .frame_err(frame_err),
        .bit_err(bit_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [23:0] data;
        int          idx;
        int          at;
        int          len;
        int          err;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Reference model state: received bits of the current pixel, completed pixels,
    // and whether the decoder is waiting for a latch gap to resynchronise.
    int          m_nbits = 0;
    logic [23:0] m_acc   = '0;
    int          m_pix   = 0;
    bit          m_sync  = 1'b1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [23:0] data, input int idx,
                        input int at, input int len, input int err);
        ev_t e;
        e.kind = kind; e.data = data; e.idx = idx; e.at = at; e.len = len; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic v, input int n);
        din = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic gap(input int l);
        if (l >= RESET_CYCLES) begin
            if (m_sync) m_sync = 1'b0;
            else if (m_nbits != 0 || m_pix != 0)
                push(K_FEND, '0, 0, 0, m_pix, (m_nbits != 0) ? 1 : 0);
            m_nbits = 0; m_pix = 0; m_acc = '0;
        end
        hold(1'b0, l);
    endtask

    task automatic pulse(input int h, input int l);
        int fall_at;
        fall_at = cyc + h;
        if (!m_sync) begin
            if (h >= HIGH_MAX) begin
                push(K_BERR, '0, 0, 0, 0, 0);
                m_nbits = 0; m_pix = 0; m_acc = '0; m_sync = 1'b1;
            end else if (h >= MIN_HIGH) begin
                m_acc = (m_acc << 1) | 24'(h >= BIT_THRESH);
                m_nbits++;
                if (m_nbits == 24) begin
                    push(K_PIX, m_acc, (m_pix < IDX_MAX) ? m_pix : IDX_MAX, fall_at + 3, 0, 0);
                    m_pix = (m_pix < IDX_MAX) ? m_pix + 1 : IDX_MAX;
                    m_nbits = 0;
                end
            end
        end
        hold(1'b1, h);
        gap(l);
    endtask

    task automatic send_bit(input bit b);
        if (b) pulse(10, 5);
        else   pulse(5, 10);
    endtask

    task automatic send_bit_rand(input bit b);
        int h;
        h = b ? $urandom_range(HIGH_MAX - 1, BIT_THRESH) : $urandom_range(BIT_THRESH - 1, MIN_HIGH);
        pulse(h, $urandom_range(12, 2));
    endtask

    task automatic send_pixel(input logic [23:0] px);
        for (int i = 23; i >= 0; i--) send_bit(px[i]);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_pixel_data"}, pixel_data, 0);
        chk({tag, "_pixel_valid"}, pixel_valid, 0);
        chk({tag, "_pixel_index"}, pixel_index, 0);
        chk({tag, "_frame_end"}, frame_end, 0);
        chk({tag, "_frame_len"}, frame_len, 0);
        chk({tag, "_frame_err"}, frame_err, 0);
        chk({tag, "_bit_err"}, bit_err, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold(1'b0, 2);
        check_zero_outputs("reset");
        rst = 1'b0;
        m_nbits = 0; m_pix = 0; m_acc = '0; m_sync = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err && !frame_end) begin
                checks++; errors++;
                $display("FAIL frame_err_alone: got frame_err=1 frame_end=0 (cycle %0d)", cyc);
            end
            if (pixel_valid || frame_end || bit_err) begin
                int kind;
                kind = pixel_valid ? K_PIX : (frame_end ? K_FEND : K_BERR);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: got kind %0d expected none (cycle %0d)", kind, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    chk("event_kind", kind, e.kind);
                    chk("strobe_count", int'(pixel_valid) + int'(frame_end) + int'(bit_err), 1);
                    if (e.kind == K_PIX && kind == K_PIX) begin
                        chk("pixel_data", pixel_data, e.data);
                        chk("pixel_index", pixel_index, e.idx);
                        chk("pixel_latency", cyc, e.at);
                    end else if (e.kind == K_FEND && kind == K_FEND) begin
                        chk("frame_len", frame_len, e.len);
                        chk("frame_err", frame_err, e.err);
                    end
                end
            end
        end
    end

    initial begin
        logic [23:0] px;
        hold(1'b0, 3);
        check_zero_outputs("init");
        rst = 1'b0;
        gap(GAP);

        // Single pixel, then latch
        send_pixel(24'hA5C3F0);
        gap(GAP);

        // Two back-to-back pixels
        send_pixel(24'hFF0000);
        send_pixel(24'h0000FF);
        gap(GAP);

        // Partial frame of 12 bits
        for (int i = 0; i < 12; i++) send_bit(i[0]);
        gap(GAP);

        // Over-long high after 5 bits, further bits ignored until a latch gap
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        pulse(30, 5);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        gap(GAP);
        send_pixel(24'h3C5A96);
        gap(GAP);

        // Longest legal high, then the shortest over-long one
        for (int i = 0; i < 23; i++) send_bit(1'b0);
        pulse(HIGH_MAX - 1, 5);
        gap(GAP);
        pulse(HIGH_MAX, 5);
        gap(GAP);

        // Glitch and threshold boundaries on 0x000001
        for (int i = 0; i < 23; i++) begin
            if (i == 10) pulse(1, 6);
            pulse((i % 2 == 0) ? BIT_THRESH - 1 : 5, 8);
        end
        pulse(1, 4);
        pulse(BIT_THRESH, 8);
        gap(GAP);

        // Reset in the middle of a pixel
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        do_reset();
        gap(GAP);
        send_pixel(24'h123456);
        gap(GAP);

        // Pixel count saturation
        for (int p = 0; p < IDX_MAX + 2; p++) begin
            px = 24'($urandom);
            for (int i = 23; i >= 0; i--) pulse(px[i] ? BIT_THRESH : MIN_HIGH, 2);
        end
        gap(GAP);

        // Randomized frames with glitches, partial pixels and occasional over-long highs
        for (int f = 0; f < 6; f++) begin
            int npix;
            npix = $urandom_range(3, 0);
            for (int p = 0; p < npix; p++) begin
                px = 24'($urandom);
                for (int i = 23; i >= 0; i--) begin
                    if ($urandom_range(15, 0) == 0) pulse(1, $urandom_range(8, 2));
                    send_bit_rand(px[i]);
                end
            end
            if ($urandom_range(2, 0) == 0) begin
                int nb;
                nb = $urandom_range(23, 1);
                for (int i = 0; i < nb; i++) send_bit_rand($urandom_range(1, 0) == 1);
            end
            if ($urandom_range(4, 0) == 0) begin
                pulse($urandom_range(HIGH_MAX + 6, HIGH_MAX), 4);
                send_bit_rand(1'b1);
            end
            gap(GAP);
        end

        hold(1'b0, 20);
        chk("pending_events", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ws2812_decoder.md
WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 SHALL have parameter BIT_THRESH, default 7; a high pulse of at least this many cycles decodes as 1, otherwise 0.
REQ-002 SHALL have parameter MIN_HIGH, default 2; high pulses shorter than this are glitches.
REQ-003 SHALL have parameter HIGH_MAX, default 24; a high pulse reaching this length is a bit error.
REQ-004 SHALL have parameter RESET_CYCLES, default 600; a low gap of this length latches the frame (50 us at 12 MHz).
REQ-005 SHALL have parameter IDX_W, default 10; this is the width of the pixel index and the frame length.
REQ-006 clk  in  1  single system clock; all logic on posedge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 din  in  1  asynchronous WS2812 serial line.
REQ-009 pixel_data  out  24  last decoded pixel, first-received bit in bit 23.
REQ-010 pixel_valid  out  1  one-cycle strobe; pixel_data and pixel_index are valid.
REQ-011 pixel_index  out  IDX_W  0-based position of the pixel in the current frame.
REQ-012 frame_end  out  1  one-cycle strobe when the latch gap is detected.
REQ-013 frame_len  out  IDX_W  complete pixels in the frame; valid with frame_end.
REQ-014 frame_err  out  1  one-cycle strobe with frame_end when partial bits were discarded.
REQ-015 bit_err  out  1  one-cycle strobe on an over-long high pulse.

Function
REQ-016 din SHALL pass through a 2-flop synchronizer (din_s); edges are detected from din_s versus its previous value.
REQ-017 The FSM SHALL have states SYNC, LOW and HIGH; rst SHALL force SYNC.
REQ-018 In SYNC, the FSM SHALL count consecutive din_s=0 cycles, restart the count on any high, and go to LOW when the count reaches RESET_CYCLES, without emitting frame_end.
REQ-019 In LOW, a rising edge SHALL go to HIGH with high_len=1, and the low counter SHALL clear.
REQ-020 In LOW, when low_len reaches RESET_CYCLES the block SHALL behave as follows:
- emit frame_end once per gap, only if at least one bit or pixel was received since the last latch;
- frame_len = pixels completed;
- frame_err=1 if bit_cnt!=0;
- clear bit_cnt, the pixel counter and the shift register;
- stay in LOW.
REQ-021 In HIGH, high_len SHALL increment each cycle; on the falling edge the FSM SHALL return to LOW, and the bit SHALL be handled as follows:
- high_len<MIN_HIGH: pulse ignored, nothing shifted;
- MIN_HIGH<=high_len<BIT_THRESH: shift in 0;
- high_len>=BIT_THRESH: shift in 1.
REQ-022 When high_len reaches HIGH_MAX, the block SHALL pulse bit_err, discard the partial pixel and bit_cnt, and go to SYNC.
REQ-023 On the 24th shifted bit, the block SHALL register pixel_data, pulse pixel_valid with pixel_index = pixel count, increment the count, and zero bit_cnt.
REQ-024 Boundaries:
- high_len = BIT_THRESH-1 decodes as 0; high_len = BIT_THRESH decodes as 1.
- The pixel count SHALL saturate at 2^IDX_W-1 and not wrap.
REQ-025 Latency: pixel_valid SHALL be high in the cycle after the third rising clk edge at which din is low following the final high (2 synchronizer stages plus 1 output register).
REQ-026 Low and high counters SHALL each be wide enough to hold their limit without overflow, and SHALL hold at their limit.
REQ-027 pixel_data and frame_len SHALL hold their values between strobes.

Reset
REQ-028 On rst, every output SHALL be 0 in the following cycle, and all counters and the shift register SHALL clear.
REQ-029 rst SHALL take priority over any simultaneous edge, gap or error event.
REQ-030 A mid-frame rst SHALL discard the partial pixel, emit no strobes, and enter SYNC.

Verification
REQ-031 Single pixel: rst, 600 cycles low, then 24 bits of 0xA5C3F0 (1 = 10 high/5 low, 0 = 5 high/10 low), then 600 low -> pixel_valid once, pixel_data=0xA5C3F0, pixel_index=0; then frame_end=1, frame_len=1, frame_err=0.
REQ-032 Two pixels back-to-back, 0xFF0000 then 0x0000FF, then 600 low -> pixel_index 0 then 1 with matching data; frame_len=2.
REQ-033 Partial frame: 12 bits then 600 low -> no pixel_valid; frame_end=1, frame_err=1, frame_len=0.
REQ-034 Over-long high of 30 cycles after 5 bits -> bit_err pulses when high_len=24; further bits are ignored until 600 low cycles; the next frame decodes correctly from bit 0.
REQ-035 Glitch and threshold test, driving 0x000001 -> pixel_data=0x000001:
- a 1-cycle high inserted between bits is ignored;
- high pulses of 6 and 7 cycles decode as 0 and 1 respectively.
REQ-036 Reset mid-pixel: rst after 10 bits -> outputs 0, no strobes; after 600 low cycles a full pixel decodes at index 0.
